alu_op_sequencer: RTL

Command-queue and result-capture stage wrapped around the 8-bit combinational ALU. Accepts operand/opcode commands over a valid/ready handshake, buffers them in a DEPTH-entry FIFO, and presents the head command to the ALU's A/B/select inputs. It registers the ALU result and Carry/Zero flags into an output holding register drained by a second valid/ready handshake. The block turns the ALU into a back-pressurable, in-order pipeline stage.

---
 rtl/alu_op_sequencer.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// alu_op_sequencer
//
// Command queue and result-capture stage wrapped around an external 8-bit
// combinational ALU. Commands (A, B, opcode) arrive over a valid/ready
// handshake and are buffered in a DEPTH-entry FIFO. The FIFO head drives the
// ALU, and the ALU result and flags are captured into a holding register that
// is drained by a second valid/ready handshake. Ordering is strictly in order.
//
// Optional feature: define ALU_SEQ_BYPASS_EN to let a command skip the FIFO
// when the FIFO is empty and the result slot is free. The command then goes
// straight to the ALU and is captured at its accept edge.
//
// Ports
//   clk, rst                    rising-edge clock, synchronous active-high reset
//   cmd_valid/cmd_ready         command handshake
//   cmd_a, cmd_b, cmd_sel       command operands and opcode
//   alu_a, alu_b, alu_sel       drive to ALU (zeros when nothing to present)
//   alu_out/alu_carry/alu_zero  combinational ALU response
//   res_valid/res_ready         result handshake
//   res_data/res_carry/res_zero registered result and flags
//   occupancy                   registered FIFO entry count
// -----------------------------------------------------------------------------
module alu_op_sequencer #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [7:0]               cmd_a,
    input  logic [7:0]               cmd_b,
    input  logic [2:0]               cmd_sel,
    output logic [7:0]               alu_a,
    output logic [7:0]               alu_b,
    output logic [2:0]               alu_sel,
    input  logic [7:0]               alu_out,
    input  logic                     alu_carry,
    input  logic                     alu_zero,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [7:0]               res_data,
    output logic                     res_carry,
    output logic                     res_zero,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = DEPTH[AW:0];
    localparam logic [AW:0]   CNT_ONE  = 1;
    localparam logic [AW-1:0] PTR_ONE  = 1;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] sel;
    } cmd_t;

    cmd_t          mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          res_valid_q, res_valid_d;
    logic [7:0]    res_data_q, res_data_d;
    logic          res_carry_q, res_carry_d;
    logic          res_zero_q, res_zero_d;

    logic fifo_empty, slot_free, push, push_fifo, issue, bypass;
    cmd_t cmd_in, head;

    assign cmd_in    = '{a: cmd_a, b: cmd_b, sel: cmd_sel};
    assign head      = mem_q[rd_ptr_q];
    // A full FIFO never accepts, even if a pop happens in the same cycle.
    assign cmd_ready = (count_q != FULL_CNT) && !rst;

    always_comb begin
        fifo_empty = (count_q == '0);
        // Result slot can take a new value if empty or being drained this cycle.
        slot_free  = !res_valid_q || res_ready;
        push       = cmd_valid && cmd_ready;
`ifdef ALU_SEQ_BYPASS_EN
        bypass     = fifo_empty && push && slot_free;
`else
        bypass     = 1'b0;
`endif
        push_fifo  = push && !bypass;
        issue      = !fifo_empty && slot_free;

        alu_a   = 8'h00;
        alu_b   = 8'h00;
        alu_sel = 3'b000;
        if (bypass) begin
            alu_a   = cmd_a;
            alu_b   = cmd_b;
            alu_sel = cmd_sel;
        end else if (!fifo_empty) begin
            alu_a   = head.a;
            alu_b   = head.b;
            alu_sel = head.sel;
        end

        wr_ptr_d = push_fifo ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = issue     ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        count_d  = count_q;
        case ({push_fifo, issue})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        // Data/flags hold their last value once drained; only valid drops.
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_carry_d = res_carry_q;
        res_zero_d  = res_zero_q;
        if (issue || bypass) begin
            res_valid_d = 1'b1;
            res_data_d  = alu_out;
            res_carry_d = alu_carry;
            res_zero_d  = alu_zero;
        end else if (res_valid_q && res_ready) begin
            res_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= 8'h00;
            res_carry_q <= 1'b0;
            res_zero_q  <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_carry_q <= res_carry_d;
            res_zero_q  <= res_zero_d;
        end
    end

    // Storage needs no reset; push_fifo is already gated off during reset.
    always_ff @(posedge clk) begin
        if (push_fifo) mem_q[wr_ptr_q] <= cmd_in;
    end

    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_carry = res_carry_q;
    assign res_zero  = res_zero_q;
    assign occupancy = count_q;

endmodule
